conv_pool_unit: RTL and testbench

Streaming convolution + max-pool engine for the image-filter datapath. Each accepted 4x4 pixel block is convolved with three independent 3x3 signed kernels, giving a 2x2 map per kernel. Each map is max-pooled to one value, then scaled, clamped and written to that kernel's result memory through a write-enable/address/data port.

---
 rtl/conv_pool_unit.sv | 180 ++++++++++++++++++
 tb/tb_conv_pool_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_unit.sv
// conv_pool_unit: streaming 3x3 convolution of a 4x4 unsigned pixel block with
// three signed kernels, 2x2 max-pool, arithmetic right shift and output fit.
// Result writes appear 4 cycles after the accepted input strobe.
// Build option: define CONV_POOL_SATURATE_EN to clamp results to 0..255;
// when it is undefined, negative results go to 0 and positive results wrap
// to their low 8 bits.
module conv_pool_unit (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] image_4x4,
    input  logic [71:0]  conv_kernel_0,
    input  logic [71:0]  conv_kernel_1,
    input  logic [71:0]  conv_kernel_2,
    input  logic [1:0]   shift,
    input  logic         input_re,
    input  logic [15:0]  input_addr,
    output logic         output_we_0,
    output logic         output_we_1,
    output logic         output_we_2,
    output logic [15:0]  output_addr_0,
    output logic [15:0]  output_addr_1,
    output logic [15:0]  output_addr_2,
    output logic [7:0]   y_0,
    output logic [7:0]   y_1,
    output logic [7:0]   y_2
);

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 21;
    localparam int STAGES = 4;

    // Sum of 9 unsigned-pixel x signed-weight products for output position (a,b).
    function automatic logic signed [ACC_W-1:0] conv_sum(
        input logic [127:0] img,
        input logic [71:0]  w,
        input int           a,
        input int           b
    );
        logic signed [ACC_W-1:0] acc;
        logic signed [16:0]      px;
        logic signed [16:0]      wt;
        logic signed [16:0]      prod;
        logic [DATA_W-1:0]       pix;
        logic [COEF_W-1:0]       wb;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pix  = img[(4*(a+i)+(b+j))*DATA_W +: DATA_W];
                wb   = w[(3*i+j)*COEF_W +: COEF_W];
                px   = {9'd0, pix};
                wt   = {{9{wb[COEF_W-1]}}, wb};
                prod = px * wt;
                acc  = acc + {{(ACC_W-17){prod[16]}}, prod};
            end
        end
        return acc;
    endfunction

    // Signed maximum of the four pooled positions.
    function automatic logic signed [ACC_W-1:0] max4(
        input logic signed [ACC_W-1:0] s0,
        input logic signed [ACC_W-1:0] s1,
        input logic signed [ACC_W-1:0] s2,
        input logic signed [ACC_W-1:0] s3
    );
        logic signed [ACC_W-1:0] m01;
        logic signed [ACC_W-1:0] m23;
        m01 = (s0 > s1) ? s0 : s1;
        m23 = (s2 > s3) ? s2 : s3;
        return (m01 > m23) ? m01 : m23;
    endfunction

    // Fit the scaled value into the 8-bit result range.
    function automatic logic [7:0] fit_output(input logic signed [ACC_W-1:0] t);
`ifdef CONV_POOL_SATURATE_EN
        if (t < 0)
            return 8'd0;
        else if (t > 21'sd255)
            return 8'd255;
        else
            return t[7:0];
`else
        if (t < 0)
            return 8'd0;
        else
            return t[7:0];
`endif
    endfunction

    logic [127:0]            img_p0;
    logic [71:0]             k_p0 [3];
    logic [1:0]              shift_p0, shift_p1, shift_p2;
    logic [15:0]             addr_p0, addr_p1, addr_p2, addr_p3;
    logic                    vld_p0, vld_p1, vld_p2, vld_p3;
    logic signed [ACC_W-1:0] s_p1 [3][4];
    logic signed [ACC_W-1:0] m_p2 [3];
    logic [7:0]              y_p3 [3];
    logic                    we_r;
    logic [15:0]             addr_r;
    logic [7:0]              y_r [3];

    // Valid bits walk alongside the data; reset drops every in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p0 <= input_re;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // Stage 0: capture block, kernels, shift and the pre-decremented address.
    always_ff @(posedge clk) begin
        img_p0   <= image_4x4;
        k_p0[0]  <= conv_kernel_0;
        k_p0[1]  <= conv_kernel_1;
        k_p0[2]  <= conv_kernel_2;
        shift_p0 <= shift;
        addr_p0  <= input_addr - 16'd1;
    end

    // Stage 1: four 3x3 convolution sums per kernel.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 2; a++)
                for (int b = 0; b < 2; b++)
                    s_p1[k][2*a+b] <= conv_sum(img_p0, k_p0[k], a, b);
        shift_p1 <= shift_p0;
        addr_p1  <= addr_p0;
    end

    // Stage 2: max-pool each kernel's 2x2 map.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            m_p2[k] <= max4(s_p1[k][0], s_p1[k][1], s_p1[k][2], s_p1[k][3]);
        shift_p2 <= shift_p1;
        addr_p2  <= addr_p1;
    end

    // Stage 3: arithmetic shift and fit to 8 bits.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            y_p3[k] <= fit_output(m_p2[k] >>> shift_p2);
        addr_p3 <= addr_p2;
    end

    // Output register: strobe follows the valid bit, data/address hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r   <= 1'b0;
            addr_r <= 16'h0000;
            for (int k = 0; k < 3; k++)
                y_r[k] <= 8'h00;
        end else begin
            we_r <= vld_p3;
            if (vld_p3) begin
                addr_r <= addr_p3;
                for (int k = 0; k < 3; k++)
                    y_r[k] <= y_p3[k];
            end
        end
    end

    assign output_we_0   = we_r;
    assign output_we_1   = we_r;
    assign output_we_2   = we_r;
    assign output_addr_0 = addr_r;
    assign output_addr_1 = addr_r;
    assign output_addr_2 = addr_r;
    assign y_0           = y_r[0];
    assign y_1           = y_r[1];
    assign y_2           = y_r[2];

endmodule

// File: tb/tb_conv_pool_unit.sv
// Directed testbench for conv_pool_unit with hand-computed expected results.
module tb_conv_pool_unit;

    logic         clk_tb;
    logic         rst;
    logic [127:0] image_4x4;
    logic [71:0]  conv_kernel_0, conv_kernel_1, conv_kernel_2;
    logic [1:0]   shift;
    logic         input_re;
    logic [15:0]  input_addr;
    logic         output_we_0, output_we_1, output_we_2;
    logic [15:0]  output_addr_0, output_addr_1, output_addr_2;
    logic [7:0]   y_0, y_1, y_2;

    int tests_run;
    int tests_failed;

`ifdef CONV_POOL_SATURATE_EN
    localparam logic [7:0] BIG_EXP = 8'hFF;
`else
    localparam logic [7:0] BIG_EXP = 8'h89;
`endif

    conv_pool_unit dut (
        .clk           (clk_tb),
        .rst           (rst),
        .image_4x4     (image_4x4),
        .conv_kernel_0 (conv_kernel_0),
        .conv_kernel_1 (conv_kernel_1),
        .conv_kernel_2 (conv_kernel_2),
        .shift         (shift),
        .input_re      (input_re),
        .input_addr    (input_addr),
        .output_we_0   (output_we_0),
        .output_we_1   (output_we_1),
        .output_we_2   (output_we_2),
        .output_addr_0 (output_addr_0),
        .output_addr_1 (output_addr_1),
        .output_addr_2 (output_addr_2),
        .y_0           (y_0),
        .y_1           (y_1),
        .y_2           (y_2)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fill_img(input logic [7:0] v);
        return {16{v}};
    endfunction

    function automatic logic [71:0] fill_k(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic logic [71:0] center_k();
        logic [71:0] k;
        k = '0;
        k[4*8 +: 8] = 8'h01;
        return k;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_we0"}, {31'd0, output_we_0}, 32'd0);
        check({tag, "_we1"}, {31'd0, output_we_1}, 32'd0);
        check({tag, "_we2"}, {31'd0, output_we_2}, 32'd0);
    endtask

    task automatic check_write(input string tag, input logic [15:0] ea,
                               input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        check({tag, "_we0"}, {31'd0, output_we_0}, 32'd1);
        check({tag, "_we1"}, {31'd0, output_we_1}, 32'd1);
        check({tag, "_we2"}, {31'd0, output_we_2}, 32'd1);
        check({tag, "_addr0"}, {16'd0, output_addr_0}, {16'd0, ea});
        check({tag, "_addr1"}, {16'd0, output_addr_1}, {16'd0, ea});
        check({tag, "_addr2"}, {16'd0, output_addr_2}, {16'd0, ea});
        check({tag, "_y0"}, {24'd0, y_0}, {24'd0, e0});
        check({tag, "_y1"}, {24'd0, y_1}, {24'd0, e1});
        check({tag, "_y2"}, {24'd0, y_2}, {24'd0, e2});
    endtask

    // One block in, checks that the write lands exactly 4 edges later for one cycle.
    task automatic run_block(input string tag, input logic [127:0] img,
                             input logic [71:0] k0, input logic [71:0] k1, input logic [71:0] k2,
                             input logic [1:0] sh, input logic [15:0] addr, input logic [15:0] ea,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        @(negedge clk_tb);
        image_4x4     = img;
        conv_kernel_0 = k0;
        conv_kernel_1 = k1;
        conv_kernel_2 = k2;
        shift         = sh;
        input_addr    = addr;
        input_re      = 1'b1;
        @(negedge clk_tb);
        input_re      = 1'b0;
        // Scramble sampled inputs: in-flight block must be unaffected.
        image_4x4     = fill_img(8'h55);
        conv_kernel_0 = fill_k(8'h80);
        conv_kernel_1 = fill_k(8'h80);
        conv_kernel_2 = fill_k(8'h80);
        shift         = 2'd1;
        input_addr    = 16'hABCD;
        repeat (3) @(posedge clk_tb);
        #1;
        check_idle({tag, "_early"});
        @(posedge clk_tb);
        #1;
        check_write(tag, ea, e0, e1, e2);
        @(posedge clk_tb);
        #1;
        check_idle({tag, "_after"});
    endtask

    logic [127:0] img_pool;

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        input_re      = 1'b0;
        image_4x4     = '0;
        conv_kernel_0 = '0;
        conv_kernel_1 = '0;
        conv_kernel_2 = '0;
        shift         = 2'd0;
        input_addr    = 16'h0000;

        repeat (3) @(posedge clk_tb);
        #1;
        check_idle("reset");
        check("reset_addr0", {16'd0, output_addr_0}, 32'd0);
        check("reset_y0", {24'd0, y_0}, 32'd0);
        check("reset_y1", {24'd0, y_1}, 32'd0);
        check("reset_y2", {24'd0, y_2}, 32'd0);
        @(negedge clk_tb);
        rst = 1'b0;

        // Identity sum, center tap of ones, negative kernel -> 9, 1, 0.
        run_block("ident", fill_img(8'h01), fill_k(8'h01), center_k(), fill_k(8'hFF),
                  2'd0, 16'h0001, 16'h0000, 8'd9, 8'd1, 8'd0);

        // Center-tap pool: max of inner pixels is 200.
        img_pool = fill_img(8'hFF);
        img_pool[(4*1+1)*8 +: 8] = 8'd10;
        img_pool[(4*1+2)*8 +: 8] = 8'd200;
        img_pool[(4*2+1)*8 +: 8] = 8'd30;
        img_pool[(4*2+2)*8 +: 8] = 8'd40;
        run_block("pool", img_pool, fill_k(8'h00), center_k(), fill_k(8'hFF),
                  2'd0, 16'h0010, 16'h000F, 8'd0, 8'd200, 8'd0);

        // Pixels 10: sum 90, center 10, all -1 weights -> 0.
        run_block("neg", fill_img(8'd10), fill_k(8'h01), center_k(), fill_k(8'hFF),
                  2'd0, 16'h0100, 16'h00FF, 8'd90, 8'd10, 8'd0);

        // 255 * 127 * 9 = 291465: clamp to 255 or wrap to 0x89; center 255 exactly.
        run_block("big", fill_img(8'hFF), fill_k(8'h7F), center_k(), fill_k(8'hFF),
                  2'd0, 16'h1234, 16'h1233, BIG_EXP, 8'd255, 8'd0);

        // Shift 2: 36>>>2=9, 4>>>2=1, -36>>>2 -> 0.
        run_block("shift2", fill_img(8'd4), fill_k(8'h01), center_k(), fill_k(8'hFF),
                  2'd2, 16'h0002, 16'h0001, 8'd9, 8'd1, 8'd0);

        // Shift 3: 36>>>3=4, 4>>>3=0.
        run_block("shift3", fill_img(8'd4), fill_k(8'h01), center_k(), fill_k(8'hFF),
                  2'd3, 16'h0003, 16'h0002, 8'd4, 8'd0, 8'd0);

        // Streaming with address wrap: three back-to-back blocks.
        @(negedge clk_tb);
        conv_kernel_0 = fill_k(8'h01);
        conv_kernel_1 = center_k();
        conv_kernel_2 = fill_k(8'hFF);
        shift         = 2'd0;
        for (int i = 0; i < 3; i++) begin
            image_4x4  = fill_img(8'(i + 1));
            input_addr = 16'(i);
            input_re   = 1'b1;
            @(negedge clk_tb);
        end
        input_re = 1'b0;
        repeat (2) @(posedge clk_tb);
        #1;
        check_write("stream0", 16'hFFFF, 8'd9, 8'd1, 8'd0);
        @(posedge clk_tb);
        #1;
        check_write("stream1", 16'h0000, 8'd18, 8'd2, 8'd0);
        @(posedge clk_tb);
        #1;
        check_write("stream2", 16'h0001, 8'd27, 8'd3, 8'd0);
        @(posedge clk_tb);
        #1;
        check_idle("stream_end");

        // Reset two cycles after a strobe, with a strobe asserted during reset.
        @(negedge clk_tb);
        image_4x4  = fill_img(8'h01);
        input_addr = 16'h0050;
        input_re   = 1'b1;
        @(negedge clk_tb);
        input_re   = 1'b0;
        @(negedge clk_tb);
        rst        = 1'b1;
        input_re   = 1'b1;
        @(negedge clk_tb);
        rst        = 1'b0;
        input_re   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_tb);
            #1;
            check_idle($sformatf("rst_c%0d", c));
        end
        check("rst_addr0", {16'd0, output_addr_0}, 32'd0);
        check("rst_addr2", {16'd0, output_addr_2}, 32'd0);
        check("rst_y0", {24'd0, y_0}, 32'd0);
        check("rst_y1", {24'd0, y_1}, 32'd0);
        check("rst_y2", {24'd0, y_2}, 32'd0);

        // Pipeline works again after reset.
        run_block("post_rst", fill_img(8'd2), fill_k(8'h01), center_k(), fill_k(8'hFF),
                  2'd1, 16'h0008, 16'h0007, 8'd9, 8'd1, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
